// File: rtl/escritor_quadro_saida.sv
// Output frame writer: takes the 2x upscaled pixel stream and stores it row-major
// into the frame buffer, flagging frames that end early or pixels outside a frame.
module escritor_quadro_saida #(
  parameter int ADDR_WIDTH = 21,
  parameter int BASE_ADDR  = 0,
  parameter int STRIDE     = 1280
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [10:0]           largura_out,
  input  logic [10:0]           altura_out,
  input  logic [7:0]            pixel_in,
  input  logic                  pixel_in_valid,
  input  logic                  fonte_done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  ocupado,
  output logic                  quadro_done,
  output logic                  erro_falta,
  output logic                  erro_excesso,
  output logic [1:0]            estado
);

  // Stream handshake: pixel_in is taken on every cycle pixel_in_valid is high;
  // there is no ready/backpressure, so the writer must accept every valid pixel.

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ESCREVENDO = 2'd1,
    S_FIM        = 2'd2
  } state_t;

  localparam logic [10:0]           STRIDE_W = 11'(STRIDE);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(STRIDE);
  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);

  state_t                  state, state_next;
  logic [10:0]             w_reg, h_reg, x, y;
  logic [ADDR_WIDTH-1:0]   row_base;
  logic [10:0]             w_lat;
  logic                    ultimo_x, ultimo, accept, fim_normal, falta;

  always_comb begin
    w_lat      = (largura_out > STRIDE_W) ? STRIDE_W : largura_out;
    ultimo_x   = (x == w_reg - 11'd1);
    ultimo     = ultimo_x && (y == h_reg - 11'd1);
    accept     = (state == S_ESCREVENDO) && pixel_in_valid;
    fim_normal = accept && ultimo;
    // fonte_done coinciding with the final pixel is the normal end, not a short frame
    falta      = (state == S_ESCREVENDO) && fonte_done && !fim_normal;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start)
          state_next = (w_lat == 11'd0 || altura_out == 11'd0) ? S_FIM : S_ESCREVENDO;
      end
      S_ESCREVENDO: begin
        if (fim_normal || falta)
          state_next = S_FIM;
      end
      S_FIM:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_reg        <= '0;
      h_reg        <= '0;
      x            <= '0;
      y            <= '0;
      row_base     <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      erro_falta   <= 1'b0;
      erro_excesso <= 1'b0;
    end else begin
      mem_we <= accept;
      if (state == S_IDLE && start) begin
        w_reg        <= w_lat;
        h_reg        <= altura_out;
        x            <= '0;
        y            <= '0;
        row_base     <= BASE_A;
        erro_falta   <= 1'b0;
        erro_excesso <= 1'b0;
      end
      if (accept) begin
        mem_addr <= row_base + ADDR_WIDTH'(x);
        mem_data <= pixel_in;
        if (ultimo_x) begin
          x        <= '0;
          y        <= y + 11'd1;
          row_base <= row_base + STRIDE_A;
        end else begin
          x <= x + 11'd1;
        end
      end
      if (falta)
        erro_falta <= 1'b1;
      if (pixel_in_valid && ((state == S_IDLE && !start) || state == S_FIM))
        erro_excesso <= 1'b1;
    end
  end

  assign ocupado     = (state == S_ESCREVENDO);
  assign quadro_done = (state == S_FIM);
  assign estado      = state;

endmodule

// File: tb/tb_escritor_quadro_saida.sv
// Directed bench for escritor_quadro_saida: narrow instance (STRIDE=8) for the
// frame tests, wide instance (STRIDE=1280) for width clamping.
module tb_escritor_quadro_saida;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0, start_w = 1'b0;
  logic [10:0] largura_out = '0, altura_out = '0;
  logic [7:0]  pixel_in = '0;
  logic        pixel_in_valid = 1'b0, fonte_done = 1'b0;

  logic        mem_we, ocupado, quadro_done, erro_falta, erro_excesso;
  logic [20:0] mem_addr;
  logic [7:0]  mem_data;
  logic [1:0]  estado;

  logic        mem_we_w, ocupado_w, quadro_done_w, erro_falta_w, erro_excesso_w;
  logic [20:0] mem_addr_w;
  logic [7:0]  mem_data_w;
  logic [1:0]  estado_w;

  int checks = 0, failures = 0;
  int done_cnt = 0, wide_cnt = 0, wide_done_cnt = 0;
  logic [20:0] wide_last_addr = '0;
  logic [7:0]  wide_last_data = '0;
  logic [28:0] exp_q[$];
  logic [28:0] e;

  escritor_quadro_saida #(.ADDR_WIDTH(21), .BASE_ADDR(0), .STRIDE(8)) dut (
    .clk(clk), .resetn(resetn), .start(start), .largura_out(largura_out),
    .altura_out(altura_out), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
    .fonte_done(fonte_done), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .ocupado(ocupado), .quadro_done(quadro_done), .erro_falta(erro_falta),
    .erro_excesso(erro_excesso), .estado(estado)
  );

  escritor_quadro_saida #(.ADDR_WIDTH(21), .BASE_ADDR(0), .STRIDE(1280)) dut_w (
    .clk(clk), .resetn(resetn), .start(start_w), .largura_out(largura_out),
    .altura_out(altura_out), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
    .fonte_done(fonte_done), .mem_we(mem_we_w), .mem_addr(mem_addr_w), .mem_data(mem_data_w),
    .ocupado(ocupado_w), .quadro_done(quadro_done_w), .erro_falta(erro_falta_w),
    .erro_excesso(erro_excesso_w), .estado(estado_w)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard / monitors
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) check("spurious_write", {3'b0, mem_addr, mem_data}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("write", {3'b0, mem_addr, mem_data}, {3'b0, e});
      end
    end
    if (quadro_done) done_cnt++;
    if (mem_we_w) begin
      wide_cnt++;
      wide_last_addr = mem_addr_w;
      wide_last_data = mem_data_w;
    end
    if (quadro_done_w) wide_done_cnt++;
  end

  // driver tasks
  task automatic drive(input logic v, input logic [7:0] p, input logic d);
    @(posedge clk); #1;
    start = 1'b0; start_w = 1'b0;
    pixel_in_valid = v; pixel_in = p; fonte_done = d;
  endtask

  task automatic begin_frame(input logic wide, input logic [10:0] w, input logic [10:0] h);
    @(posedge clk); #1;
    start = !wide; start_w = wide;
    largura_out = w; altura_out = h;
    pixel_in_valid = 1'b0; fonte_done = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic expect_write(input int addr, input logic [7:0] d);
    exp_q.push_back({21'(addr), d});
  endtask

  logic [7:0] px[4];
  int         ad[4];
  int         done_before;

  initial begin
    px = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    ad = '{0, 1, 8, 9};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_estado", 32'(estado), 0);
    check("rst_outs", {mem_we, ocupado, quadro_done, erro_falta, erro_excesso}, 0);
    check("rst_addr_data", {mem_addr, mem_data}, 0);
    @(negedge clk); resetn = 1'b1;

    // 1: 2x2 back-to-back
    begin_frame(1'b0, 11'd2, 11'd2);
    for (int i = 0; i < 4; i++) begin
      expect_write(ad[i], px[i]);
      drive(1'b1, px[i], 1'b0);
    end
    drive(1'b0, 8'h00, 1'b0); sample();
    check("t1_done", quadro_done, 1);
    check("t1_ocupado_fim", ocupado, 0);
    drive(1'b0, 8'h00, 1'b0); sample();
    check("t1_done_clr", quadro_done, 0);
    check("t1_idle", 32'(estado), 0);
    check("t1_q_empty", exp_q.size(), 0);

    // 2: same frame with 3 idle cycles between pixels
    begin_frame(1'b0, 11'd2, 11'd2);
    for (int i = 0; i < 4; i++) begin
      expect_write(ad[i], px[i]);
      drive(1'b1, px[i], 1'b0);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'b0, 8'h00, 1'b0); sample();
          check("t2_ocupado_gap", ocupado, 1);
        end
      end
    end
    drive(1'b0, 8'h00, 1'b0); sample();
    check("t2_done", quadro_done, 1);
    check("t2_q_empty", exp_q.size(), 0);

    // 3: W=4 H=2, fonte_done with the 5th pixel
    begin_frame(1'b0, 11'd4, 11'd2);
    for (int i = 0; i < 5; i++) begin
      expect_write((i < 4) ? i : 8, 8'h31 + 8'(i));
      drive(1'b1, 8'h31 + 8'(i), i == 4);
    end
    drive(1'b0, 8'h00, 1'b0); sample();
    check("t3_done", quadro_done, 1);
    check("t3_erro_falta", erro_falta, 1);
    drive(1'b0, 8'h00, 1'b0); sample();
    check("t3_idle", 32'(estado), 0);
    check("t3_falta_sticky", erro_falta, 1);
    check("t3_q_empty", exp_q.size(), 0);

    // 4: W=2 H=1, fonte_done with the last pixel
    begin_frame(1'b0, 11'd2, 11'd1);
    expect_write(0, 8'h41); drive(1'b1, 8'h41, 1'b0);
    expect_write(1, 8'h42); drive(1'b1, 8'h42, 1'b1);
    drive(1'b0, 8'h00, 1'b0); sample();
    check("t4_done", quadro_done, 1);
    check("t4_no_falta", erro_falta, 0);

    // 5: valid pixel while idle, then a new start clears the flag
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b0, 8'h00, 1'b0); sample();
    check("t5_excesso", erro_excesso, 1);
    check("t5_no_write", mem_we, 0);
    begin_frame(1'b0, 11'd2, 11'd1);
    drive(1'b0, 8'h00, 1'b0); sample();
    check("t5_excesso_clr", erro_excesso, 0);
    check("t5_ocupado", ocupado, 1);
    expect_write(0, 8'h61); drive(1'b1, 8'h61, 1'b0);
    expect_write(1, 8'h62); drive(1'b1, 8'h62, 1'b0);
    drive(1'b0, 8'h00, 1'b0); sample();
    check("t5_done", quadro_done, 1);

    // 6: reset after 3 of 8 pixels
    begin_frame(1'b0, 11'd4, 11'd2);
    for (int i = 0; i < 3; i++) begin
      expect_write(i, 8'h71 + 8'(i));
      drive(1'b1, 8'h71 + 8'(i), 1'b0);
    end
    drive(1'b0, 8'h00, 1'b0); sample();
    check("t6_mid_ocupado", ocupado, 1);
    done_before = done_cnt;
    resetn = 1'b0; #1;
    check("t6_rst_outs", {mem_we, ocupado, quadro_done, erro_falta, erro_excesso}, 0);
    check("t6_rst_addr_data", {mem_addr, mem_data}, 0);
    check("t6_rst_estado", 32'(estado), 0);
    check("t6_q_empty", exp_q.size(), 0);
    @(negedge clk); resetn = 1'b1;
    repeat (3) begin
      drive(1'b0, 8'h00, 1'b0); sample();
      check("t6_no_stale_done", quadro_done, 0);
    end
    begin_frame(1'b0, 11'd2, 11'd1);
    expect_write(0, 8'h81); drive(1'b1, 8'h81, 1'b0);
    expect_write(1, 8'h82); drive(1'b1, 8'h82, 1'b0);
    drive(1'b0, 8'h00, 1'b0); sample();
    check("t6_restart_done", quadro_done, 1);
    check("t6_done_count", done_cnt, done_before + 1);

    // 7a: width 2000 clamps to 1280 on the wide instance
    begin_frame(1'b1, 11'd2000, 11'd1);
    for (int i = 0; i < 1280; i++) drive(1'b1, 8'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b0); sample();
    check("t7_wide_done", quadro_done_w, 1);
    check("t7_wide_writes", wide_cnt, 1280);
    check("t7_wide_last_addr", 32'(wide_last_addr), 1279);
    check("t7_wide_last_data", 32'(wide_last_data), 32'hFF);
    check("t7_wide_done_cnt", wide_done_cnt, 1);

    // 7b: zero width gives a done pulse and no writes
    begin_frame(1'b0, 11'd0, 11'd3);
    drive(1'b0, 8'h00, 1'b0); sample();
    check("t7_zero_done", quadro_done, 1);
    check("t7_zero_no_we", mem_we, 0);
    drive(1'b0, 8'h00, 1'b0); sample();
    check("t7_zero_idle", 32'(estado), 0);
    check("final_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
